// File: rtl/osc_pkg.sv
// rtl/osc_pkg.sv - shared width constant and count type for the oscillator
package osc_pkg;
    localparam int OSC_WIDTH = 19;

    typedef logic [OSC_WIDTH-1:0] osc_count_t;
endpackage

// File: rtl/osc_counter_next.sv
// rtl/osc_counter_next.sv - combinational terminal compare and next-count logic
module osc_counter_next
    import osc_pkg::*;
#(
    parameter int WIDTH = OSC_WIDTH
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] max,
    output logic             wrap,
    output logic [WIDTH-1:0] count_next
);
    // Incrementing only when count < max means count+1 can never overflow.
    always_comb begin
        wrap       = (count >= max);
        count_next = wrap ? '0 : count + WIDTH'(1);
    end
endmodule

// File: rtl/oscillator.sv
// rtl/oscillator.sv - free-running phase counter; square output under OSCILLATOR_SQUARE_EN
module oscillator
    import osc_pkg::*;
#(
    parameter int WIDTH = OSC_WIDTH
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] count,
    output logic             wrap
`ifdef OSCILLATOR_SQUARE_EN
    ,
    output logic             square
`endif
);
    logic [WIDTH-1:0] count_next;

    osc_counter_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .count     (count),
        .max       (max),
        .wrap      (wrap),
        .count_next(count_next)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

`ifdef OSCILLATOR_SQUARE_EN
    // One toggle per period gives a square wave of period 2*(max+1).
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            square <= 1'b0;
        end else if (wrap) begin
            square <= ~square;
        end
    end
`endif
endmodule

// File: tb/tb_oscillator.sv
// tb/tb_oscillator.sv - self-checking bench for oscillator with an in-bench reference model
`timescale 1ns/1ps
module tb_oscillator;
    localparam int W  = 19;
    localparam int W8 = 8;

    logic          clk  = 1'b0;
    logic          nrst = 1'b0;
    logic [W-1:0]  max  = '0;
    logic [W-1:0]  count;
    logic          wrap;
    logic [W8-1:0] max8 = 8'hFF;
    logic [W8-1:0] count8;
    logic          wrap8;
`ifdef OSCILLATOR_SQUARE_EN
    logic          square;
    logic          square8;
`endif

    oscillator #(.WIDTH(W)) dut (
        .clk   (clk),
        .nrst  (nrst),
        .max   (max),
        .count (count),
        .wrap  (wrap)
`ifdef OSCILLATOR_SQUARE_EN
        ,
        .square(square)
`endif
    );

    oscillator #(.WIDTH(W8)) dut8 (
        .clk   (clk),
        .nrst  (nrst),
        .max   (max8),
        .count (count8),
        .wrap  (wrap8)
`ifdef OSCILLATOR_SQUARE_EN
        ,
        .square(square8)
`endif
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: phase advances by one per edge and returns to zero once it has reached max.
    longint m_count  = 0;
    longint m_count8 = 0;
    bit     m_sq     = 1'b0;
    bit     m_sq8    = 1'b0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_count  <= 0;
            m_count8 <= 0;
            m_sq     <= 1'b0;
            m_sq8    <= 1'b0;
        end else begin
            if (m_count >= longint'(max)) begin
                m_count <= 0;
                m_sq    <= ~m_sq;
            end else begin
                m_count <= m_count + 1;
            end
            if (m_count8 >= longint'(max8)) begin
                m_count8 <= 0;
                m_sq8    <= ~m_sq8;
            end else begin
                m_count8 <= m_count8 + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("model_count", 64'(count), 64'(m_count));
        check("model_wrap", 64'(wrap), 64'(m_count >= longint'(max)));
        check("model_count8", 64'(count8), 64'(m_count8));
        check("model_wrap8", 64'(wrap8), 64'(m_count8 >= longint'(max8)));
`ifdef OSCILLATOR_SQUARE_EN
        check("model_square", 64'(square), 64'(m_sq));
        check("model_square8", 64'(square8), 64'(m_sq8));
`endif
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        step();
        nrst = 1'b1;
    endtask

    task automatic run_to(input logic [W-1:0] target, input int budget, input string name);
        int n = 0;
        while (count !== target && n < budget) begin
            step();
            n++;
        end
        check(name, 64'(count), 64'(target));
    endtask

    initial begin
        int n;
        int r;

        // Reset behaviour and first edges after release
        nrst = 1'b0;
        max  = 19'd146237;
        step();
        step();
        check("reset_count", 64'(count), 64'd0);
`ifdef OSCILLATOR_SQUARE_EN
        check("reset_square", 64'(square), 64'd0);
`endif
        max = 19'd5;
        step();
        check("reset_ignores_max", 64'(count), 64'd0);
        max  = 19'd146237;
        nrst = 1'b1;
        step();
        check("release_edge1", 64'(count), 64'd1);
        step();
        check("release_edge2", 64'(count), 64'd2);
        step();
        check("release_edge3", 64'(count), 64'd3);

        // Lowering max below the count, then raising it mid-period
        max = 19'd200;
        do_reset();
        run_to(19'd100, 200, "dyn_reach_100");
        max = 19'd50;
        step();
        check("dyn_lower_restart", 64'(count), 64'd0);
        run_to(19'd20, 100, "dyn_reach_20");
        max = 19'd300;
        step();
        check("dyn_raise_continue", 64'(count), 64'd21);

        // Asynchronous reset between edges
        max = 19'd146237;
        do_reset();
        run_to(19'd500, 600, "mid_reach_500");
        nrst = 1'b0;
        #1;
        check("mid_reset_count", 64'(count), 64'd0);
`ifdef OSCILLATOR_SQUARE_EN
        check("mid_reset_square", 64'(square), 64'd0);
`endif
        step();
        nrst = 1'b1;
        step();
        check("mid_reset_restart", 64'(count), 64'd1);

        // max = 0 holds count at zero with wrap high
        max = 19'd0;
        step();
        check("max0_load", 64'(count), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("max0_count", 64'(count), 64'd0);
            check("max0_wrap", 64'(wrap), 64'd1);
        end
        do_reset();
        step();
        check("max0_after_reset", 64'(count), 64'd0);

        // Terminal value, wrap and exact period
        max = 19'd20000;
        do_reset();
        run_to(19'd20000, 20100, "period_reach_max");
        check("period_wrap_at_max", 64'(wrap), 64'd1);
        step();
        check("period_after_max", 64'(count), 64'd0);
        n = 1;
        while (count !== 19'd20000 && n < 21000) begin
            step();
            n++;
        end
        check("period_length", 64'(n), 64'd20001);

        // All-ones terminal count on the narrow instance
        max8 = 8'hFF;
        do_reset();
        n = 0;
        while (count8 !== 8'hFF && n < 300) begin
            step();
            n++;
        end
        check("allones_reach", 64'(count8), 64'hFF);
        check("allones_wrap", 64'(wrap8), 64'd1);
        step();
        check("allones_to_zero", 64'(count8), 64'd0);

`ifdef OSCILLATOR_SQUARE_EN
        // Square with max = 3: one toggle every four edges
        max  = 19'd3;
        nrst = 1'b0;
        step();
        check("sq_in_reset", 64'(square), 64'd0);
        nrst = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check("sq_sequence", 64'(square), 64'(((i / 4) % 2)));
        end
`endif

        // Randomized max changes and reset pulses against the model
        max  = 19'd17;
        max8 = 8'd9;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
                max = W'($urandom_range(0, 40));
            end else if (r < 8) begin
                max = W'($urandom_range(0, 2000));
            end else if (r < 11) begin
                max8 = W8'($urandom_range(0, 255));
            end else if (r == 99) begin
                nrst = 1'b0;
                #1;
                nrst = 1'b1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not complete, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/oscillator.md
OSCILLATOR -- requirements
Module: oscillator

Interface
REQ-001 Parameter WIDTH, default 19: bit width of max and count.
REQ-002 clk  input  1  rising-edge system clock (10 kHz nominal).
REQ-003 nrst  input  1  asynchronous active-low reset.
REQ-004 max  input  WIDTH  terminal count; sampled every cycle, no internal register.
REQ-005 count  output  WIDTH  registered free-running phase counter.
REQ-006 wrap  output  1  combinational; high in the cycle whose count is the terminal value.
REQ-007 square  output  1  registered 50%-duty-style toggle output; present only with OSCILLATOR_SQUARE_EN.
REQ-008 The design SHALL use one clock, clk; reset nrst SHALL be asynchronous and active-low.

Function
REQ-009 On each rising clk with nrst high: if count >= max, count SHALL load 0; otherwise count SHALL load count+1.
REQ-010 Period SHALL be max+1 cycles, with count sequence 0,1,...,max,0,...
REQ-011 wrap SHALL equal (count >= max), unsigned compare, full WIDTH.
REQ-012 max = 0: count SHALL stay 0 and wrap SHALL stay high.
REQ-013 max lowered below the current count mid-period: count SHALL load 0 on the next edge, never counting past max.
REQ-014 max raised mid-period: count SHALL keep incrementing to the new max, with no restart.
REQ-015 Increment SHALL never overflow; for max = all-ones, count SHALL reach all-ones, then load 0.
REQ-016 With the feature enabled, square SHALL toggle on every rising edge where wrap is high.

Reset
REQ-017 While nrst is low, count SHALL be 0 and square SHALL be 0, regardless of clk.
REQ-018 max SHALL have no effect during reset.
REQ-019 After nrst deasserts, the first rising edge SHALL load 1, or 0 if max = 0.
REQ-020 Reset asserted mid-period SHALL clear count immediately; counting SHALL restart from 0.

Configuration
REQ-021 Macro OSCILLATOR_SQUARE_EN SHALL control the square feature.
REQ-022 With OSCILLATOR_SQUARE_EN defined, the square port and its toggle register SHALL exist.
REQ-023 Without OSCILLATOR_SQUARE_EN, square SHALL be absent from the port list, and count/wrap behaviour SHALL be unchanged.

Structure
REQ-024 Package osc_pkg SHALL hold the WIDTH default constant (19) and a typedef osc_count_t of WIDTH bits.
REQ-025 The terminal compare and next-count logic SHALL live in one sub-module, osc_counter_next, which is purely combinational.
REQ-026 All state SHALL be held in the top module oscillator.

Verification
REQ-027 Reset: nrst low, then released at a negedge with max = 146237 -> count = 0 during reset, then 1, 2, 3 on successive edges.
REQ-028 Full period: max = 146237, run 200000 cycles -> count reaches 146237 with wrap = 1, next value 0, period exactly 146238 cycles.
REQ-029 Boundary: max = 0 -> count constant 0, wrap constant 1; max = 19'h7FFFF -> count reaches 19'h7FFFF, then 0.
REQ-030 Dynamic max: count = 100, max changed 200 -> 50 -> next count 0; max changed 50 -> 300 at count 20 -> continues 21.
REQ-031 Mid-operation reset: nrst pulsed low between edges at count = 500 -> count 0 immediately; square 0 if enabled.
REQ-032 Square, with OSCILLATOR_SQUARE_EN and max = 3 -> square toggles every 4 cycles, 0 after reset, 1 after first wrap.
